ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one two-port RAM (one write port, one registered read port) between two clients, A and B.
//  Write and read paths are arbitrated independently, each round-robin, with a same-cycle grant.
//  Read data returns one cycle after issue and is steered to the issuing client by a tag pipeline.
//  Sits between client logic and the RAM; both RAM clocks are tied to clk_i.
// PARAMETERS
//  WIDTH  16   data width; must equal the RAM WIDTH
//  DEPTH  256  RAM depth; AW = $clog2(DEPTH)
// PORTS
//  clk_i            in   1      single clock; reset is asynchronous and active-low
//  rst_n_i          in   1      asynchronous, active-low reset
//  a_wr_req_i       in   1      client A write request; held with address/data until granted
//  a_wr_addr_i      in   AW     client A write address
//  a_wr_data_i      in   WIDTH  client A write data
//  a_wr_gnt_o       out  1      A write accepted this cycle (combinational)
//  a_rd_req_i       in   1      client A read request
//  a_rd_addr_i      in   AW     client A read address
//  a_rd_gnt_o       out  1      A read accepted this cycle (combinational)
//  a_rd_dv_o        out  1      A read data valid, 1 cycle after a_rd_gnt_o
//  a_rd_data_o      out  WIDTH  A read data; 0 when a_rd_dv_o=0
//  b_*              --   --     client B: same nine ports and rules as client A
//  ram_wr_addr_o    out  AW     to RAM wr_addr_i
//  ram_wr_dv_o      out  1      to RAM wr_dv_i
//  ram_wr_data_o    out  WIDTH  to RAM wr_data_i
//  ram_rd_addr_o    out  AW     to RAM rd_addr_i
//  ram_rd_en_o      out  1      to RAM rd_en_i
//  ram_rd_data_i    in   WIDTH  from RAM rd_data_o
// BEHAVIOUR
//  - Each path (write, read) keeps a 1-bit last-served pointer, states LAST_A and LAST_B.
//    Reset value is LAST_B, so A wins the first contention.
//  - Grant rule per path:
//    only A requests -> A; only B requests -> B;
//    both request -> the client not last served; none -> no grant.
//    The pointer updates only on a grant; it holds otherwise.
//  - Grants are combinational from the requests and the pointer. A grant means the request is consumed
//    this cycle. The client may drop the request or present a new one next cycle.
//  - ram_wr_*: mux of the granted client; ram_wr_dv_o = any write grant. Address/data are 0 when idle.
//  - ram_rd_*: mux of the granted client; ram_rd_en_o = any read grant. Address is 0 when idle.
//  - Return path: registered tag {valid, owner} captures {ram_rd_en_o, owner} each cycle.
//    x_rd_dv_o = tag.valid & (tag.owner==x); x_rd_data_o = ram_rd_data_i when x_rd_dv_o, else 0.
//    The RAM's own rd_dv_o is ignored because it has no reset.
//  - Latency: a read granted in cycle N returns dv/data in cycle N+1. Back-to-back reads reach 1 per cycle total.
//  - Write and read in the same cycle are independent. A same-address read returns the OLD contents (RAM read-before-write).
//  - A request that is never granted keeps its address/data stable; the arbiter does not check this.
//  - Starvation bound: a continuously requesting client is granted within 2 cycles.
//  - Reset, including mid-operation: pointers go to LAST_B and tag.valid to 0.
//    All *_gnt_o, *_rd_dv_o and ram_*_dv/en are 0 while rst_n_i=0.
//    A read in flight at reset is discarded; no dv appears after reset.
//  - Gating outputs in reset: the grant outputs are combinational, so they are gated with a registered reset
//    flag (0 during reset). The first grant is possible in the first edge cycle after deassert.
// CONFIGURATION
//  COLLISION_FLAG_EN defined:
//    adds output collision_o (1 bit, registered, reset 0).
//    It pulses 1 cycle after a cycle where ram_wr_dv_o & ram_rd_en_o & (ram_wr_addr_o==ram_rd_addr_o).
//  COLLISION_FLAG_EN undefined: the port and its logic are absent. Arbitration is unchanged.
// TESTING
//  1 Reset, then A and B both read-request every cycle at addresses 5/9 -> grants A,B,A,B...
//    Dv/data arrive 1 cycle later at the correct client.
//  2 A writes 0xBEEF to addr 3 (grant same cycle); next cycle B reads addr 3 -> b_rd_dv_o=1, b_rd_data_o=0xBEEF one cycle later.
//  3 Same cycle: A writes 0x1234 to 7 and B reads 7 (old value 0x0000) -> B gets 0x0000.
//    collision_o=1 the next cycle when COLLISION_FLAG_EN is defined.
//  4 Only B requests for 4 cycles -> 4 consecutive B grants.
//    A then joins -> A granted first, then alternating.
//  5 Assert rst_n_i the cycle after a read grant -> no dv on either client, ever.
//    After release, A wins the first contention.
//  6 Write contention: A and B each write 8 distinct addresses simultaneously -> all 16 writes land (read back and check).
//    Grants alternate; no write is lost.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one write port and one registered read port between clients A and B.
// Optional COLLISION_FLAG_EN adds collision_o, flagging a same-address write/read cycle.
module ram_port_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,

    input  logic             a_wr_req_i,
    input  logic [AW-1:0]    a_wr_addr_i,
    input  logic [WIDTH-1:0] a_wr_data_i,
    output logic             a_wr_gnt_o,
    input  logic             a_rd_req_i,
    input  logic [AW-1:0]    a_rd_addr_i,
    output logic             a_rd_gnt_o,
    output logic             a_rd_dv_o,
    output logic [WIDTH-1:0] a_rd_data_o,

    input  logic             b_wr_req_i,
    input  logic [AW-1:0]    b_wr_addr_i,
    input  logic [WIDTH-1:0] b_wr_data_i,
    output logic             b_wr_gnt_o,
    input  logic             b_rd_req_i,
    input  logic [AW-1:0]    b_rd_addr_i,
    output logic             b_rd_gnt_o,
    output logic             b_rd_dv_o,
    output logic [WIDTH-1:0] b_rd_data_o,

    output logic [AW-1:0]    ram_wr_addr_o,
    output logic             ram_wr_dv_o,
    output logic [WIDTH-1:0] ram_wr_data_o,
    output logic [AW-1:0]    ram_rd_addr_o,
    output logic             ram_rd_en_o,
    input  logic [WIDTH-1:0] ram_rd_data_i
`ifdef COLLISION_FLAG_EN
    ,
    output logic             collision_o
`endif
);

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_e;

    // Read-return tag; owner 0 = client A, 1 = client B.
    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

    logic    run_q;
    last_e   wr_last_q, wr_last_d;
    last_e   rd_last_q, rd_last_d;
    logic    wr_gnt_a, wr_gnt_b;
    logic    rd_gnt_a, rd_gnt_b;
    rd_tag_t rd_tag_q, rd_tag_d;

    // Registered reset flag keeps combinational grants low through reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_last_q <= LAST_B;
            rd_last_q <= LAST_B;
        end else begin
            wr_last_q <= wr_last_d;
            rd_last_q <= rd_last_d;
        end
    end

    // Write path: lone requester wins, contention goes to the client not served last.
    always_comb begin
        wr_gnt_a  = 1'b0;
        wr_gnt_b  = 1'b0;
        wr_last_d = wr_last_q;
        if (run_q) begin
            if (a_wr_req_i && (!b_wr_req_i || (wr_last_q == LAST_B))) begin
                wr_gnt_a  = 1'b1;
                wr_last_d = LAST_A;
            end else if (b_wr_req_i) begin
                wr_gnt_b  = 1'b1;
                wr_last_d = LAST_B;
            end
        end
    end

    always_comb begin
        rd_gnt_a  = 1'b0;
        rd_gnt_b  = 1'b0;
        rd_last_d = rd_last_q;
        if (run_q) begin
            if (a_rd_req_i && (!b_rd_req_i || (rd_last_q == LAST_B))) begin
                rd_gnt_a  = 1'b1;
                rd_last_d = LAST_A;
            end else if (b_rd_req_i) begin
                rd_gnt_b  = 1'b1;
                rd_last_d = LAST_B;
            end
        end
    end

    assign a_wr_gnt_o = wr_gnt_a;
    assign b_wr_gnt_o = wr_gnt_b;
    assign a_rd_gnt_o = rd_gnt_a;
    assign b_rd_gnt_o = rd_gnt_b;

    // RAM-side muxes; address and data idle at zero.
    always_comb begin
        ram_wr_dv_o   = wr_gnt_a | wr_gnt_b;
        ram_wr_addr_o = '0;
        ram_wr_data_o = '0;
        if (wr_gnt_a) begin
            ram_wr_addr_o = a_wr_addr_i;
            ram_wr_data_o = a_wr_data_i;
        end else if (wr_gnt_b) begin
            ram_wr_addr_o = b_wr_addr_i;
            ram_wr_data_o = b_wr_data_i;
        end
    end

    always_comb begin
        ram_rd_en_o   = rd_gnt_a | rd_gnt_b;
        ram_rd_addr_o = '0;
        if (rd_gnt_a) begin
            ram_rd_addr_o = a_rd_addr_i;
        end else if (rd_gnt_b) begin
            ram_rd_addr_o = b_rd_addr_i;
        end
    end

    // Tag follows the RAM read latency; the RAM's own valid is unreset and unused.
    always_comb begin
        rd_tag_d       = '0;
        rd_tag_d.valid = ram_rd_en_o;
        rd_tag_d.owner = rd_gnt_b;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_tag_q <= '0;
        end else begin
            rd_tag_q <= rd_tag_d;
        end
    end

    assign a_rd_dv_o   = rd_tag_q.valid & ~rd_tag_q.owner;
    assign b_rd_dv_o   = rd_tag_q.valid &  rd_tag_q.owner;
    assign a_rd_data_o = a_rd_dv_o ? ram_rd_data_i : '0;
    assign b_rd_data_o = b_rd_dv_o ? ram_rd_data_i : '0;

`ifdef COLLISION_FLAG_EN
    logic collision_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= ram_wr_dv_o & ram_rd_en_o & (ram_wr_addr_o == ram_rd_addr_o);
        end
    end

    assign collision_o = collision_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural read-before-write RAM.
// Build with COLLISION_FLAG_EN defined to also check collision_o.
module tb_ram_port_arbiter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             a_wr_req, b_wr_req, a_rd_req, b_rd_req;
    logic [AW-1:0]    a_wr_addr, b_wr_addr, a_rd_addr, b_rd_addr;
    logic [WIDTH-1:0] a_wr_data, b_wr_data;
    logic             a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt;
    logic             a_rd_dv, b_rd_dv;
    logic [WIDTH-1:0] a_rd_data, b_rd_data;
    logic [AW-1:0]    ram_wr_addr, ram_rd_addr;
    logic             ram_wr_dv, ram_rd_en;
    logic [WIDTH-1:0] ram_wr_data, ram_rd_data;
`ifdef COLLISION_FLAG_EN
    logic             collision;
`endif

    ram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .a_wr_req_i(a_wr_req), .a_wr_addr_i(a_wr_addr), .a_wr_data_i(a_wr_data), .a_wr_gnt_o(a_wr_gnt),
        .a_rd_req_i(a_rd_req), .a_rd_addr_i(a_rd_addr), .a_rd_gnt_o(a_rd_gnt),
        .a_rd_dv_o(a_rd_dv), .a_rd_data_o(a_rd_data),
        .b_wr_req_i(b_wr_req), .b_wr_addr_i(b_wr_addr), .b_wr_data_i(b_wr_data), .b_wr_gnt_o(b_wr_gnt),
        .b_rd_req_i(b_rd_req), .b_rd_addr_i(b_rd_addr), .b_rd_gnt_o(b_rd_gnt),
        .b_rd_dv_o(b_rd_dv), .b_rd_data_o(b_rd_data),
        .ram_wr_addr_o(ram_wr_addr), .ram_wr_dv_o(ram_wr_dv), .ram_wr_data_o(ram_wr_data),
        .ram_rd_addr_o(ram_rd_addr), .ram_rd_en_o(ram_rd_en), .ram_rd_data_i(ram_rd_data)
`ifdef COLLISION_FLAG_EN
        , .collision_o(collision)
`endif
    );

    // Behavioural RAM: registered read, read-before-write; cleared while reset is low.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            ram_rd_data <= '0;
        end else begin
            if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
            if (ram_wr_dv) mem[ram_wr_addr] <= ram_wr_data;
        end
    end

    typedef struct {
        logic             awr;
        logic [AW-1:0]    awa;
        logic [WIDTH-1:0] awd;
        logic             bwr;
        logic [AW-1:0]    bwa;
        logic [WIDTH-1:0] bwd;
        logic             ard;
        logic [AW-1:0]    ara;
        logic             brd;
        logic [AW-1:0]    bra;
        logic [3:0]       gnt;   // {a_wr, b_wr, a_rd, b_rd}
        logic             adv;
        logic [WIDTH-1:0] adat;
        logic             bdv;
        logic [WIDTH-1:0] bdat;
        logic             coll;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vec [NVEC];

    int total = 0;
    int pass  = 0;

    function automatic vec_t mk(logic awr, logic [AW-1:0] awa, logic [WIDTH-1:0] awd,
                                logic bwr, logic [AW-1:0] bwa, logic [WIDTH-1:0] bwd,
                                logic ard, logic [AW-1:0] ara, logic brd, logic [AW-1:0] bra,
                                logic [3:0] gnt, logic adv, logic [WIDTH-1:0] adat,
                                logic bdv, logic [WIDTH-1:0] bdat, logic coll);
        vec_t v;
        v.awr = awr; v.awa = awa; v.awd = awd;
        v.bwr = bwr; v.bwa = bwa; v.bwd = bwd;
        v.ard = ard; v.ara = ara; v.brd = brd; v.bra = bra;
        v.gnt = gnt; v.adv = adv; v.adat = adat; v.bdv = bdv; v.bdat = bdat; v.coll = coll;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        a_wr_req = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        b_wr_req = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        a_rd_req = 1'b0; a_rd_addr = '0;
        b_rd_req = 1'b0; b_rd_addr = '0;
    endtask

    task automatic drive(input vec_t v);
        a_wr_req = v.awr; a_wr_addr = v.awa; a_wr_data = v.awd;
        b_wr_req = v.bwr; b_wr_addr = v.bwa; b_wr_data = v.bwd;
        a_rd_req = v.ard; a_rd_addr = v.ara;
        b_rd_req = v.brd; b_rd_addr = v.bra;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " a_wr_gnt"}, 32'(a_wr_gnt), 32'd0);
        chk({tag, " b_wr_gnt"}, 32'(b_wr_gnt), 32'd0);
        chk({tag, " a_rd_gnt"}, 32'(a_rd_gnt), 32'd0);
        chk({tag, " b_rd_gnt"}, 32'(b_rd_gnt), 32'd0);
        chk({tag, " ram_wr_dv"}, 32'(ram_wr_dv), 32'd0);
        chk({tag, " ram_rd_en"}, 32'(ram_rd_en), 32'd0);
        chk({tag, " a_rd_dv"}, 32'(a_rd_dv), 32'd0);
        chk({tag, " b_rd_dv"}, 32'(b_rd_dv), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Scenarios: preload contention, alternating reads, write-then-read,
        // same-cycle collision, B-only streak then A joins.
        vec[0]  = mk(1, 8'd5, 16'h0505, 1, 8'd9, 16'h0909, 0, 8'd0, 0, 8'd0, 4'b1000, 0, 16'h0, 0, 16'h0, 0);
        vec[1]  = mk(0, 8'd0, 16'h0,    1, 8'd9, 16'h0909, 0, 8'd0, 0, 8'd0, 4'b0100, 0, 16'h0, 0, 16'h0, 0);
        vec[2]  = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 1, 8'd5, 1, 8'd9, 4'b0010, 0, 16'h0,    0, 16'h0,    0);
        vec[3]  = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 1, 8'd5, 1, 8'd9, 4'b0001, 1, 16'h0505, 0, 16'h0,    0);
        vec[4]  = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 1, 8'd5, 1, 8'd9, 4'b0010, 0, 16'h0,    1, 16'h0909, 0);
        vec[5]  = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 1, 8'd5, 1, 8'd9, 4'b0001, 1, 16'h0505, 0, 16'h0,    0);
        vec[6]  = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 0, 8'd0, 0, 8'd0, 4'b0000, 0, 16'h0,    1, 16'h0909, 0);
        vec[7]  = mk(1, 8'd3, 16'hBEEF, 0, 8'd0, 16'h0, 0, 8'd0, 0, 8'd0, 4'b1000, 0, 16'h0, 0, 16'h0,    0);
        vec[8]  = mk(0, 8'd0, 16'h0,    0, 8'd0, 16'h0, 0, 8'd0, 1, 8'd3, 4'b0001, 0, 16'h0, 0, 16'h0,    0);
        vec[9]  = mk(0, 8'd0, 16'h0,    0, 8'd0, 16'h0, 0, 8'd0, 0, 8'd0, 4'b0000, 0, 16'h0, 1, 16'hBEEF, 0);
        vec[10] = mk(1, 8'd7, 16'h1234, 0, 8'd0, 16'h0, 0, 8'd0, 1, 8'd7, 4'b1001, 0, 16'h0, 0, 16'h0,    0);
        vec[11] = mk(0, 8'd0, 16'h0,    0, 8'd0, 16'h0, 0, 8'd0, 0, 8'd0, 4'b0000, 0, 16'h0, 1, 16'h0000, 1);
        vec[12] = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 0, 8'd0, 1, 8'd7, 4'b0001, 0, 16'h0,    0, 16'h0,    0);
        vec[13] = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 0, 8'd0, 1, 8'd9, 4'b0001, 0, 16'h0,    1, 16'h1234, 0);
        vec[14] = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 0, 8'd0, 1, 8'd9, 4'b0001, 0, 16'h0,    1, 16'h0909, 0);
        vec[15] = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 0, 8'd0, 1, 8'd9, 4'b0001, 0, 16'h0,    1, 16'h0909, 0);
        vec[16] = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 1, 8'd5, 1, 8'd9, 4'b0010, 0, 16'h0,    1, 16'h0909, 0);
        vec[17] = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 1, 8'd5, 1, 8'd9, 4'b0001, 1, 16'h0505, 0, 16'h0,    0);
        vec[18] = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 1, 8'd5, 1, 8'd9, 4'b0010, 0, 16'h0,    1, 16'h0909, 0);
        vec[19] = mk(0, 8'd0, 16'h0, 0, 8'd0, 16'h0, 0, 8'd0, 0, 8'd0, 4'b0000, 1, 16'h0505, 0, 16'h0,    0);

        // Reset with every request raised: nothing may be granted.
        rst_n = 1'b0;
        idle_inputs();
        a_wr_req = 1'b1; b_wr_req = 1'b1; a_rd_req = 1'b1; b_rd_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
`ifdef COLLISION_FLAG_EN
        chk("reset collision", 32'(collision), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_inputs();

        for (int i = 0; i < NVEC; i++) begin
            logic [AW-1:0]    exp_wa, exp_ra;
            logic [WIDTH-1:0] exp_wd;
            @(posedge clk);
            #1;
            drive(vec[i]);
            @(negedge clk);
            exp_wa = vec[i].gnt[3] ? vec[i].awa : (vec[i].gnt[2] ? vec[i].bwa : '0);
            exp_wd = vec[i].gnt[3] ? vec[i].awd : (vec[i].gnt[2] ? vec[i].bwd : '0);
            exp_ra = vec[i].gnt[1] ? vec[i].ara : (vec[i].gnt[0] ? vec[i].bra : '0);
            chk($sformatf("v%0d a_wr_gnt", i), 32'(a_wr_gnt), 32'(vec[i].gnt[3]));
            chk($sformatf("v%0d b_wr_gnt", i), 32'(b_wr_gnt), 32'(vec[i].gnt[2]));
            chk($sformatf("v%0d a_rd_gnt", i), 32'(a_rd_gnt), 32'(vec[i].gnt[1]));
            chk($sformatf("v%0d b_rd_gnt", i), 32'(b_rd_gnt), 32'(vec[i].gnt[0]));
            chk($sformatf("v%0d ram_wr_dv", i), 32'(ram_wr_dv), 32'(vec[i].gnt[3] | vec[i].gnt[2]));
            chk($sformatf("v%0d ram_rd_en", i), 32'(ram_rd_en), 32'(vec[i].gnt[1] | vec[i].gnt[0]));
            chk($sformatf("v%0d ram_wr_addr", i), 32'(ram_wr_addr), 32'(exp_wa));
            chk($sformatf("v%0d ram_wr_data", i), 32'(ram_wr_data), 32'(exp_wd));
            chk($sformatf("v%0d ram_rd_addr", i), 32'(ram_rd_addr), 32'(exp_ra));
            chk($sformatf("v%0d a_rd_dv", i), 32'(a_rd_dv), 32'(vec[i].adv));
            chk($sformatf("v%0d a_rd_data", i), 32'(a_rd_data), 32'(vec[i].adat));
            chk($sformatf("v%0d b_rd_dv", i), 32'(b_rd_dv), 32'(vec[i].bdv));
            chk($sformatf("v%0d b_rd_data", i), 32'(b_rd_data), 32'(vec[i].bdat));
`ifdef COLLISION_FLAG_EN
            chk($sformatf("v%0d collision", i), 32'(collision), 32'(vec[i].coll));
`endif
        end

        // Reset the cycle after a read grant: the in-flight read must vanish.
        @(posedge clk);
        #1;
        idle_inputs();
        a_rd_req = 1'b1; a_rd_addr = 8'd5;
        @(negedge clk);
        chk("rst5 a_rd_gnt before reset", 32'(a_rd_gnt), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        a_wr_req = 1'b1; b_wr_req = 1'b1; b_rd_req = 1'b1; b_rd_addr = 8'd9;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_reset_outputs($sformatf("rst5 c%0d", c));
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk_reset_outputs("rst5 release");
        @(posedge clk);
        #1;
        a_rd_req = 1'b1; a_rd_addr = 8'd5; b_rd_req = 1'b1; b_rd_addr = 8'd9;
        @(negedge clk);
        chk("rst5 first contention a_rd_gnt", 32'(a_rd_gnt), 32'd1);
        chk("rst5 first contention b_rd_gnt", 32'(b_rd_gnt), 32'd0);
        chk("rst5 no stale a_rd_dv", 32'(a_rd_dv), 32'd0);
        chk("rst5 no stale b_rd_dv", 32'(b_rd_dv), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("rst5 a_rd_dv after grant", 32'(a_rd_dv), 32'd1);
        chk("rst5 b_rd_dv after grant", 32'(b_rd_dv), 32'd0);

        // Write contention: 8 writes per client, alternating A first, then read all back.
        begin
            int ai = 0;
            int bi = 0;
            for (int k = 0; k < 16; k++) begin
                @(posedge clk);
                #1;
                a_wr_req  = (ai < 8);
                a_wr_addr = AW'(16 + ai);
                a_wr_data = WIDTH'(16'hA000 + ai);
                b_wr_req  = (bi < 8);
                b_wr_addr = AW'(32 + bi);
                b_wr_data = WIDTH'(16'hB000 + bi);
                @(negedge clk);
                chk($sformatf("wr6 k%0d a_wr_gnt", k), 32'(a_wr_gnt), 32'((k % 2) == 0));
                chk($sformatf("wr6 k%0d b_wr_gnt", k), 32'(b_wr_gnt), 32'((k % 2) == 1));
                if (a_wr_gnt) ai++;
                if (b_wr_gnt) bi++;
            end
            chk("wr6 a writes granted", 32'(ai), 32'd8);
            chk("wr6 b writes granted", 32'(bi), 32'd8);
        end
        for (int k = 0; k <= 16; k++) begin
            @(posedge clk);
            #1;
            idle_inputs();
            if (k < 16) begin
                a_rd_req  = 1'b1;
                a_rd_addr = (k < 8) ? AW'(16 + k) : AW'(32 + k - 8);
            end
            @(negedge clk);
            if (k > 0) begin
                logic [WIDTH-1:0] exp_d;
                exp_d = (k - 1 < 8) ? WIDTH'(16'hA000 + k - 1) : WIDTH'(16'hB000 + k - 9);
                chk($sformatf("rb6 k%0d a_rd_dv", k), 32'(a_rd_dv), 32'd1);
                chk($sformatf("rb6 k%0d a_rd_data", k), 32'(a_rd_data), 32'(exp_d));
            end
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
